dsi_tx_line_buffer: RTL

Parametrised single-clock pixel line buffer between the Avalon-ST pixel source and the DSI packet assembler. It stores pixel words together with their end-of-line marker and presents a show-ahead read port. Line readiness is signalled either by complete stored lines or by a byte threshold, whichever comes first. It supersedes the fixed 32x1024 dual-clock pixel buffer wherever the pixel source and the PHY-side logic share one clock.

---
 rtl/dsi_tx_pkg.sv | 27 ++
 rtl/dsi_sync_fifo_ram.sv | 36 +++
 rtl/dsi_tx_line_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dsi_tx_pkg.sv
// Shared constants and elaboration-time helpers for the DSI TX line buffer.
package dsi_tx_pkg;

   localparam int unsigned DSI_DATA_WIDTH = 32;

   // Ceiling log2. Returns 0 for values 0 and 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Number of whole pixel words needed to cover a byte threshold (rounded up).
   function automatic int unsigned thr_words(input int unsigned bytes,
                                             input int unsigned data_width);
      int unsigned bpw;
      bpw = data_width / 8;
      return (bytes + bpw - 1) / bpw;
   endfunction

endpackage

// File: rtl/dsi_sync_fifo_ram.sv
// Simple dual-port synchronous RAM with a registered read port.
// The read register doubles as the line buffer's show-ahead output stage.
module dsi_sync_fifo_ram #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; cleared on reset so the head word reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/dsi_tx_line_buffer.sv
// Single-clock pixel line buffer between an Avalon-ST pixel source and the
// DSI packet assembler. Show-ahead read port, line/threshold readiness flag.
// Optional framing checker enabled by DSI_TX_LINE_BUF_FRAMING_CHECK_EN.
module dsi_tx_line_buffer
   import dsi_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH          = DSI_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH          = 1024,
   parameter int unsigned LINE_TRESHOLD_BYTES = 640,
   parameter int unsigned READY_MARGIN        = 16,
   parameter int unsigned LINE_CNT_W          = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         avl_st_in_data,
   input  logic                          avl_st_in_valid,
   input  logic                          avl_st_in_startofpacket,
   input  logic                          avl_st_in_endofpacket,
   output logic                          avl_st_in_ready,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          fifo_eop,
   output logic                          fifo_not_empty,
   output logic                          fifo_line_ready,
   input  logic                          fifo_read_ack,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw,
   output logic [LINE_CNT_W-1:0]         fifo_lines
`ifdef DSI_TX_LINE_BUF_FRAMING_CHECK_EN
   ,
   output logic                          pkt_error
`endif
);

   localparam int unsigned AW        = clog2(FIFO_DEPTH);
   localparam int unsigned UW        = AW + 1;
   // Internal line count is wide enough to hold any true count the array can carry.
   localparam int unsigned LW        = (LINE_CNT_W + 1 > UW) ? LINE_CNT_W + 1 : UW;
   localparam int unsigned THR_WORDS = thr_words(LINE_TRESHOLD_BYTES, DATA_WIDTH);
   localparam int unsigned RDY_LIMIT = FIFO_DEPTH - READY_MARGIN;
   localparam int unsigned LINE_MAX  = (2 ** LINE_CNT_W) - 1;

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LW-1:0]         lines_q;
   logic [LW-1:0]         lines_next;
   logic [LINE_CNT_W-1:0] lines_sat;
   logic [UW-1:0]         usedw_next;
   logic [DATA_WIDTH:0]   ram_q;
   logic                  wr;
   logic                  rd;
   logic                  arr_nonempty;
   logic                  load;
   logic                  line_inc;
   logic                  line_dec;

   // Handshakes, prefetch decision and next fill level.
   always_comb begin
      wr           = avl_st_in_valid & avl_st_in_ready;
      rd           = fifo_read_ack & fifo_not_empty;
      arr_nonempty = (wr_ptr != rd_ptr);
      load         = arr_nonempty & (~fifo_not_empty | rd);
      usedw_next   = fifo_usedw + UW'(wr) - UW'(rd);
   end

   // Stored-line count: EOP in increments, EOP out decrements, both cancel.
   always_comb begin
      line_inc   = wr & avl_st_in_endofpacket;
      line_dec   = rd & fifo_eop;
      lines_next = lines_q;
      if (line_inc && !line_dec) begin
         lines_next = lines_q + LW'(1);
      end else if (line_dec && !line_inc) begin
         lines_next = lines_q - LW'(1);
      end
      lines_sat = (lines_next > LW'(LINE_MAX)) ? '1 : lines_next[LINE_CNT_W-1:0];
   end

   // Pointers, head-valid flag, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_not_empty  <= 1'b0;
         fifo_usedw      <= '0;
         lines_q         <= '0;
         fifo_lines      <= '0;
         fifo_line_ready <= 1'b0;
         avl_st_in_ready <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (load) begin
            rd_ptr         <= rd_ptr + AW'(1);
            fifo_not_empty <= 1'b1;
         end else if (rd) begin
            fifo_not_empty <= 1'b0;
         end
         fifo_usedw      <= usedw_next;
         lines_q         <= lines_next;
         fifo_lines      <= lines_sat;
         fifo_line_ready <= (lines_next != '0) | (usedw_next >= UW'(THR_WORDS));
         avl_st_in_ready <= (usedw_next < UW'(RDY_LIMIT));
      end
   end

   dsi_sync_fifo_ram #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr),
      .wr_addr (wr_ptr),
      .wr_data ({avl_st_in_endofpacket, avl_st_in_data}),
      .rd_en   (load),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   assign fifo_data = ram_q[DATA_WIDTH-1:0];
   assign fifo_eop  = ram_q[DATA_WIDTH];

`ifdef DSI_TX_LINE_BUF_FRAMING_CHECK_EN
   logic in_line;

   // Framing tracker: SOP must open a line, non-SOP words must continue one.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_line   <= 1'b0;
         pkt_error <= 1'b0;
      end else if (wr) begin
         if (avl_st_in_startofpacket == in_line) begin
            pkt_error <= 1'b1;
         end
         in_line <= ~avl_st_in_endofpacket;
      end
   end
`else
   logic unused_sop;
   assign unused_sop = avl_st_in_startofpacket;
`endif

endmodule
